// File: rtl/axi_lite_reg_bridge.sv
// axi_lite_reg_bridge: AXI-Lite slave bridged onto a req/ack register bus with round-robin R/W arbitration and wait-state timeout
module axi_lite_reg_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    reg_req,
    output logic                    reg_we,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wdata,
    output logic [DATA_WIDTH/8-1:0] reg_wstrb,
    input  logic                    reg_ack,
    input  logic [DATA_WIDTH-1:0]   reg_rdata,
    input  logic                    reg_err
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, WR_BUS, RD_BUS, WR_RESP, RD_RESP} state_t;

    state_t                state_q, state_d;
    logic                  active_q, active_d;
    logic                  aw_full_q, aw_full_d;
    logic                  w_full_q, w_full_d;
    logic                  last_wr_q, last_wr_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         wstrb_q, wstrb_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  timeout;

    // readys come only from registered state so no input reaches them combinationally
    assign awready   = active_q && !aw_full_q;
    assign wready    = active_q && !w_full_q;
    assign arready   = active_q && state_q == IDLE && (!(aw_full_q && w_full_q) || last_wr_q);
    assign reg_req   = state_q == WR_BUS || state_q == RD_BUS;
    assign reg_we    = state_q == WR_BUS;
    assign reg_addr  = reg_we ? awaddr_q : (state_q == RD_BUS ? araddr_q : '0);
    assign reg_wdata = reg_we ? wdata_q : '0;
    assign reg_wstrb = reg_we ? wstrb_q : '0;
    assign bvalid    = state_q == WR_RESP;
    assign rvalid    = state_q == RD_RESP;
    assign bresp     = bresp_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
    assign timeout   = cnt_q == CW'(TIMEOUT - 1);

    // next-state: holder capture, arbitration, bus wait/timeout and response hand-off
    always_comb begin
        state_d   = state_q;
        active_d  = 1'b1;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        last_wr_d = last_wr_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        cnt_d     = cnt_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        if (awvalid && awready) begin
            aw_full_d = 1'b1;
            awaddr_d  = awaddr;
        end
        if (wvalid && wready) begin
            w_full_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (arvalid && arready) begin
                    araddr_d  = araddr;
                    last_wr_d = 1'b0;
                    state_d   = RD_BUS;
                end else if (aw_full_q && w_full_q) begin
                    last_wr_d = 1'b1;
                    state_d   = WR_BUS;
                end
            end
            WR_BUS: begin
                cnt_d = cnt_q + 1'b1;
                if (reg_ack || timeout) begin
                    bresp_d   = (reg_ack && !reg_err) ? 2'b00 : 2'b10;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                    state_d   = WR_RESP;
                end
            end
            RD_BUS: begin
                cnt_d = cnt_q + 1'b1;
                if (reg_ack || timeout) begin
                    rresp_d = (reg_ack && !reg_err) ? 2'b00 : 2'b10;
                    rdata_d = reg_ack ? reg_rdata : '0;
                    state_d = RD_RESP;
                end
            end
            WR_RESP: state_d = bready ? IDLE : WR_RESP;
            RD_RESP: state_d = rready ? IDLE : RD_RESP;
            default: state_d = IDLE;
        endcase
    end

    // state registers; reset discards holders and any in-flight access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            active_q  <= 1'b0;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            last_wr_q <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            cnt_q     <= '0;
            bresp_q   <= '0;
            rresp_q   <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            last_wr_q <= last_wr_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            cnt_q     <= cnt_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_reg_bridge.sv
// tb_axi_lite_reg_bridge: directed checks of the AXI-Lite to register-bus bridge
module tb_axi_lite_reg_bridge;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata, reg_addr, reg_wdata;
    logic [3:0]  wstrb = '0, reg_wstrb;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic        awready, wready, bvalid, arready, rvalid, reg_req, reg_we, reg_ack;
    logic [1:0]  bresp, rresp;
    logic [31:0] prdata = '0;
    logic        perr = 0, noack = 0;
    int          wait_n = 0;
    int          pcnt = 0;
    int          total = 0, bad = 0;
    logic [1:0]  g [4];
    int          n;
    logic        prev;

    axi_lite_reg_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .reg_req(reg_req), .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_wstrb(reg_wstrb), .reg_ack(reg_ack), .reg_rdata(prdata), .reg_err(perr)
    );

    always #5 clk = ~clk;

    // peripheral model: acks after wait_n wait states unless noack
    assign reg_ack = reg_req && !noack && pcnt == wait_n;
    always @(posedge clk) pcnt <= (reg_req && !reg_ack) ? pcnt + 1 : 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        tick;
        tick;
        chk("rst_awready", awready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_req", reg_req, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1;
        chk("rel_awready", awready, 0);
        tick;
        chk("act_awready", awready, 1);
        chk("act_arready", arready, 1);

        // write with AW and W together, zero-wait ack
        awaddr = 32'h10; awvalid = 1; wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1;
        tick;
        awvalid = 0; wvalid = 0;
        chk("w1_req_lat", reg_req, 0);
        chk("w1_awready", awready, 0);
        tick;
        chk("w1_req", reg_req, 1);
        chk("w1_we", reg_we, 1);
        chk("w1_addr", reg_addr, 32'h10);
        chk("w1_wdata", reg_wdata, 32'hDEADBEEF);
        chk("w1_wstrb", reg_wstrb, 4'hF);
        tick;
        chk("w1_bvalid", bvalid, 1);
        chk("w1_bresp", bresp, 0);
        chk("w1_req_off", reg_req, 0);
        bready = 1;
        tick;
        chk("w1_bdone", bvalid, 0);
        bready = 0;

        // W four cycles before AW
        wdata = 32'h0000A5A5; wstrb = 4'h3; wvalid = 1;
        tick;
        wvalid = 0;
        chk("w2_wready", wready, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("w2_noreq", reg_req, 0);
        end
        awaddr = 32'h44; awvalid = 1;
        tick;
        awvalid = 0;
        chk("w2_noreq_aw", reg_req, 0);
        tick;
        chk("w2_req", reg_req, 1);
        chk("w2_wstrb", reg_wstrb, 4'h3);
        chk("w2_wdata", reg_wdata, 32'h0000A5A5);
        chk("w2_addr", reg_addr, 32'h44);
        chk("w2_wready_bus", wready, 0);
        tick;
        chk("w2_bvalid", bvalid, 1);
        bready = 1;
        tick;
        chk("w2_bdone", bvalid, 0);
        chk("w2_wready_end", wready, 1);
        bready = 0;

        // read with 3 wait states and error
        wait_n = 3; perr = 1; prdata = 32'h12345678;
        araddr = 32'h20; arvalid = 1;
        tick;
        arvalid = 0;
        chk("r1_req", reg_req, 1);
        chk("r1_we", reg_we, 0);
        chk("r1_addr", reg_addr, 32'h20);
        chk("r1_wdata", reg_wdata, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("r1_wait", rvalid, 0);
        end
        tick;
        chk("r1_rvalid", rvalid, 1);
        chk("r1_rdata", rdata, 32'h12345678);
        chk("r1_rresp", rresp, 2'b10);
        tick;
        tick;
        chk("r1_hold", rvalid, 1);
        chk("r1_hold_data", rdata, 32'h12345678);
        rready = 1;
        tick;
        chk("r1_rdone", rvalid, 0);
        rready = 0;

        // read timeout
        noack = 1; perr = 0;
        araddr = 32'h24; arvalid = 1;
        tick;
        arvalid = 0;
        for (int i = 0; i < 15; i++) tick;
        chk("to_r_req15", reg_req, 1);
        tick;
        chk("to_r_req16", reg_req, 0);
        chk("to_r_rvalid", rvalid, 1);
        chk("to_r_rresp", rresp, 2'b10);
        chk("to_r_rdata", rdata, 0);
        rready = 1;
        tick;
        rready = 0;

        // write timeout
        awaddr = 32'h28; awvalid = 1; wdata = 32'h1; wstrb = 4'hF; wvalid = 1;
        tick;
        awvalid = 0; wvalid = 0;
        tick;
        for (int i = 0; i < 15; i++) tick;
        chk("to_w_req15", reg_req, 1);
        tick;
        chk("to_w_req16", reg_req, 0);
        chk("to_w_bvalid", bvalid, 1);
        chk("to_w_bresp", bresp, 2'b10);
        bready = 1;
        tick;
        bready = 0;

        // ack on the last cycle beats the timeout
        noack = 0; wait_n = 15; prdata = 32'h0BADF00D;
        araddr = 32'h2C; arvalid = 1;
        tick;
        arvalid = 0;
        for (int i = 0; i < 15; i++) tick;
        chk("ack16_req", reg_req, 1);
        tick;
        chk("ack16_rvalid", rvalid, 1);
        chk("ack16_rresp", rresp, 0);
        chk("ack16_rdata", rdata, 32'h0BADF00D);
        rready = 1;
        tick;
        rready = 0;

        // alternation with write pending and arvalid held
        wait_n = 0; bready = 1; rready = 1;
        awaddr = 32'h50; awvalid = 1; wdata = 32'h55; wvalid = 1;
        tick;
        araddr = 32'h60; arvalid = 1;
        for (int i = 0; i < 4; i++) g[i] = 2'd2;
        n = 0;
        prev = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            tick;
            if (reg_req && !prev) begin
                g[n] = {1'b0, reg_we};
                n++;
            end
            prev = reg_req;
        end
        chk("alt_g0_w", g[0], 2'd1);
        chk("alt_g1_r", g[1], 2'd0);
        chk("alt_g2_w", g[2], 2'd1);
        chk("alt_g3_r", g[3], 2'd0);
        awvalid = 0; wvalid = 0; arvalid = 0;
        for (int i = 0; i < 10; i++) tick;
        bready = 0; rready = 0;

        // reset during WR_BUS
        noack = 1;
        awaddr = 32'h70; awvalid = 1; wdata = 32'h77; wvalid = 1;
        tick;
        awvalid = 0; wvalid = 0;
        tick;
        chk("rb_req", reg_req, 1);
        #2 reset = 0;
        #1;
        chk("rb_req_drop", reg_req, 0);
        chk("rb_awready", awready, 0);
        chk("rb_wready", wready, 0);
        chk("rb_arready", arready, 0);
        chk("rb_bvalid", bvalid, 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1;
        noack = 0; wait_n = 0; prdata = 32'hCAFEF00D; perr = 0;
        chk("rb_rel_arready", arready, 0);
        tick;
        chk("rb_act_arready", arready, 1);
        araddr = 32'h30; arvalid = 1;
        tick;
        arvalid = 0;
        chk("rb_r_req", reg_req, 1);
        chk("rb_r_addr", reg_addr, 32'h30);
        tick;
        chk("rb_r_rvalid", rvalid, 1);
        chk("rb_r_rdata", rdata, 32'hCAFEF00D);
        chk("rb_r_rresp", rresp, 0);
        chk("rb_no_b", bvalid, 0);
        rready = 1;
        tick;
        chk("rb_rdone", rvalid, 0);
        rready = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
